// File: rtl/cmt_intc_pkg.sv
// cmt_intc_pkg
// Shared constants and types for the cmt_intc interrupt controller:
//   - default source count and vector base
//   - priority field width
//   - APB register byte offsets
//   - FSM state type (IDLE / HOLD)
package cmt_intc_pkg;

    localparam int          NSRC_DEF     = 8;
    localparam logic [7:0]  VEC_BASE_DEF = 8'h40;
    localparam int          PRIO_W       = 4;

    localparam logic [7:0]  OFF_IPR   = 8'h00;
    localparam logic [7:0]  OFF_IER   = 8'h04;
    localparam logic [7:0]  OFF_IMR   = 8'h08;
    localparam logic [7:0]  OFF_IPEND = 8'h0C;
    localparam logic [7:0]  OFF_ISTAT = 8'h10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/cmt_intc_if.sv
// cmt_intc_if
// Bundles the APB configuration port and the CPU interrupt handshake.
//   APB:  psel_i, pwrite_i, penable_i, paddr_i[7:0], pwdata_i[31:0]  (to slave)
//         prdata_o[31:0], pslverr_o, pready_o                       (from slave)
//   CPU:  int_ack_i                                                  (to slave)
//         int_req_o, int_level_o[3:0], int_vec_o[7:0]                (from slave)
// Handshake: an APB access completes in the cycle where psel_i and
// penable_i are both high (pready_o is always 1). The CPU acknowledges a
// presented interrupt by holding int_ack_i high for one cycle while
// int_req_o is high; an ack with int_req_o low is ignored.
interface cmt_intc_if;

    logic        psel_i;
    logic        pwrite_i;
    logic        penable_i;
    logic [7:0]  paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pslverr_o;
    logic        pready_o;

    logic        int_req_o;
    logic [3:0]  int_level_o;
    logic [7:0]  int_vec_o;
    logic        int_ack_i;

    modport slave (
        input  psel_i, pwrite_i, penable_i, paddr_i, pwdata_i, int_ack_i,
        output prdata_o, pslverr_o, pready_o, int_req_o, int_level_o, int_vec_o
    );

    modport master (
        output psel_i, pwrite_i, penable_i, paddr_i, pwdata_i, int_ack_i,
        input  prdata_o, pslverr_o, pready_o, int_req_o, int_level_o, int_vec_o
    );

endinterface

// File: rtl/cmt_intc_arb.sv
// cmt_intc_arb
// Combinational priority arbiter over the candidate vector.
//   i_cand[NSRC-1:0]        candidate sources (pending & enabled & prio != 0)
//   i_prio[NSRC*PRIO_W-1:0] priority field per source
//   o_valid                 at least one candidate exists
//   o_level[PRIO_W-1:0]     priority of the winner (0 when none)
//   o_idx[IDXW-1:0]         index of the winner (0 when none)
// Highest priority wins; ties go to the lowest source index.
module cmt_intc_arb
    import cmt_intc_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int IDXW = 3
) (
    input  logic [NSRC-1:0]        i_cand,
    input  logic [NSRC*PRIO_W-1:0] i_prio,
    output logic                   o_valid,
    output logic [PRIO_W-1:0]      o_level,
    output logic [IDXW-1:0]        o_idx
);

    logic              w_valid;
    logic [PRIO_W-1:0] w_level;
    logic [IDXW-1:0]   w_idx;

    // Ascending scan with a strict '>' compare: an equal priority found
    // later never displaces an earlier (lower-index) winner.
    always_comb begin
        w_valid = 1'b0;
        w_level = '0;
        w_idx   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (i_cand[i] && (!w_valid || (i_prio[i*PRIO_W +: PRIO_W] > w_level))) begin
                w_valid = 1'b1;
                w_level = i_prio[i*PRIO_W +: PRIO_W];
                w_idx   = IDXW'(i);
            end
        end
    end

    assign o_valid = w_valid;
    assign o_level = w_level;
    assign o_idx   = w_idx;

endmodule

// File: rtl/cmt_intc.sv
// cmt_intc
// Interrupt controller behind the two-channel compare-match timer.
// Latches/masks NSRC interrupt lines, arbitrates by 4-bit priority and
// presents one level/vector request to the CPU with an ack handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   src_i[NSRC-1:0]   raw interrupt lines (bit0 = cmt0, bit1 = cmt1)
//   dbg_state_o       current FSM state
//   bus               APB slave + CPU request/ack (cmt_intc_if.slave)
// Registers: 0x00 IPR, 0x04 IER, 0x08 IMR, 0x0C IPEND (W1C, edge bits),
//            0x10 ISTAT (read-only).
module cmt_intc
    import cmt_intc_pkg::*;
#(
    parameter int         NSRC     = NSRC_DEF,
    parameter logic [7:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_i,
    output state_t          dbg_state_o,
    cmt_intc_if.slave       bus
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    // Configuration and capture state
    logic [NSRC*PRIO_W-1:0] r_ipr;
    logic [NSRC-1:0]        r_ier;
    logic [NSRC-1:0]        r_imr;
    logic [NSRC-1:0]        r_pend_e;
    logic [NSRC-1:0]        r_src_q;
    logic [NSRC-1:0]        r_src_d;

    // Presented request
    state_t                 r_state;
    logic                   r_req;
    logic [PRIO_W-1:0]      r_level;
    logic [7:0]             r_vec;
    logic [IDXW-1:0]        r_idx;

    logic                   w_wr;
    logic                   w_access;
    logic                   w_mapped;
    logic [NSRC-1:0]        w_edge_set;
    logic [NSRC-1:0]        w_w1c;
    logic [NSRC-1:0]        w_ack_clr;
    logic                   w_ack_fire;
    logic [NSRC-1:0]        w_pend;
    logic [NSRC-1:0]        w_prio_nz;
    logic [NSRC-1:0]        w_cand;
    logic                   w_valid;
    logic [PRIO_W-1:0]      w_level;
    logic [IDXW-1:0]        w_idx;
    logic [31:0]            w_istat;
    logic [31:0]            w_rdata;

    assign w_access = bus.psel_i & bus.penable_i;
    assign w_wr     = w_access & bus.pwrite_i;

    // Edge-mode bits live in r_pend_e; level-mode bits follow src_q directly.
    assign w_edge_set = r_src_q & ~r_src_d & r_imr;
    assign w_w1c      = (w_wr && (bus.paddr_i == OFF_IPEND)) ? (bus.pwdata_i[NSRC-1:0] & r_imr) : '0;
    assign w_ack_fire = (r_state == ST_IDLE) && r_req && bus.int_ack_i;
    assign w_ack_clr  = w_ack_fire ? (NSRC'(1) << r_idx) : '0;
    assign w_pend     = (r_pend_e & r_imr) | (r_src_q & ~r_imr);

    always_comb begin
        w_prio_nz = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_prio_nz[i] = |r_ipr[i*PRIO_W +: PRIO_W];
        end
    end

    assign w_cand = w_pend & r_ier & w_prio_nz;

    cmt_intc_arb #(
        .NSRC (NSRC),
        .IDXW (IDXW)
    ) u_arb (
        .i_cand  (w_cand),
        .i_prio  (r_ipr),
        .o_valid (w_valid),
        .o_level (w_level),
        .o_idx   (w_idx)
    );

    // Registers, source capture and pending. A same-cycle edge set is OR-ed
    // in after the clears, so it beats both W1C and ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ipr    <= '0;
            r_ier    <= '0;
            r_imr    <= '0;
            r_pend_e <= '0;
            r_src_q  <= '0;
            r_src_d  <= '0;
        end else begin
            r_src_q  <= src_i;
            r_src_d  <= r_src_q;
            r_pend_e <= (r_pend_e & ~(w_w1c | w_ack_clr)) | w_edge_set;
            if (w_wr) begin
                case (bus.paddr_i)
                    OFF_IPR: r_ipr <= bus.pwdata_i[NSRC*PRIO_W-1:0];
                    OFF_IER: r_ier <= bus.pwdata_i[NSRC-1:0];
                    OFF_IMR: r_imr <= bus.pwdata_i[NSRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Request FSM: IDLE tracks the arbiter each cycle; an accepted ack
    // forces one HOLD cycle with the request low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_level <= '0;
            r_vec   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ack_fire) begin
                        r_req   <= 1'b0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_req   <= w_valid;
                        r_level <= w_valid ? w_level : '0;
                        r_vec   <= w_valid ? (VEC_BASE + 8'(w_idx)) : 8'h00;
                        r_idx   <= w_idx;
                    end
                end
                ST_HOLD: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_istat = {14'd0, (r_state == ST_HOLD), r_req, r_vec, 4'd0, r_level};

    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (bus.paddr_i)
            OFF_IPR:   w_rdata = 32'(r_ipr);
            OFF_IER:   w_rdata = 32'(r_ier);
            OFF_IMR:   w_rdata = 32'(r_imr);
            OFF_IPEND: w_rdata = 32'(w_pend);
            OFF_ISTAT: w_rdata = w_istat;
            default:   w_mapped = 1'b0;
        endcase
    end

    assign bus.prdata_o    = bus.psel_i ? w_rdata : 32'd0;
    assign bus.pslverr_o   = w_access & ~w_mapped;
    assign bus.pready_o    = 1'b1;
    assign bus.int_req_o   = r_req;
    assign bus.int_level_o = r_level;
    assign bus.int_vec_o   = r_vec;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_cmt_intc.sv
// tb_cmt_intc
// Bench for cmt_intc: table of APB register accesses with expected
// read data / error flags, followed by hand-written interrupt sequences.
module tb_cmt_intc;
    import cmt_intc_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    state_t     dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    cmt_intc_if bus ();

    cmt_intc #(
        .NSRC     (8),
        .VEC_BASE (8'h40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_i       (src),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_err;
    } reg_vec_t;

    reg_vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver tasks: called at a negedge, return at a negedge (or just after).
    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        bus.psel_i    = 1'b1;
        bus.pwrite_i  = 1'b1;
        bus.penable_i = 1'b0;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        @(negedge clk);
        bus.penable_i = 1'b1;
        #1 err = bus.pslverr_o;
        @(negedge clk);
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        bus.psel_i    = 1'b1;
        bus.pwrite_i  = 1'b0;
        bus.penable_i = 1'b0;
        bus.paddr_i   = addr;
        @(negedge clk);
        bus.penable_i = 1'b1;
        #1;
        data = bus.prdata_o;
        err  = bus.pslverr_o;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, e);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        chk(name, d, exp);
    endtask

    task automatic ack_pulse();
        bus.int_ack_i = 1'b1;
        @(negedge clk);
        bus.int_ack_i = 1'b0;
    endtask

    // Bounded wait for a request; an expired budget counts as a failure.
    task automatic wait_req(input string name, input int budget);
        int k;
        k = 0;
        while (bus.int_req_o !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(bus.int_req_o), 32'd1);
    endtask

    task automatic run_tbl(input int lo, input int hi);
        logic [31:0] d;
        logic        e;
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].is_write) begin
                apb_write(tbl[i].addr, tbl[i].wdata, e);
                chk($sformatf("tbl%0d_wr_err", i), 32'(e), 32'(tbl[i].exp_err));
            end else begin
                apb_read(tbl[i].addr, d, e);
                chk($sformatf("tbl%0d_rd_data", i), d, tbl[i].exp);
                chk($sformatf("tbl%0d_rd_err", i), 32'(e), 32'(tbl[i].exp_err));
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        // is_write, addr, wdata, exp, exp_err
        tbl[0]  = '{1'b0, 8'h00, 32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b0, 8'h04, 32'h0,        32'h0,        1'b0};
        tbl[2]  = '{1'b0, 8'h08, 32'h0,        32'h0,        1'b0};
        tbl[3]  = '{1'b0, 8'h0C, 32'h0,        32'h0,        1'b0};
        tbl[4]  = '{1'b0, 8'h10, 32'h0,        32'h0,        1'b0};
        tbl[5]  = '{1'b1, 8'h00, 32'h00000021, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 8'h04, 32'hFFFFFF03, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 8'h08, 32'h00000003, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 8'h00, 32'h0,        32'h00000021, 1'b0};
        tbl[9]  = '{1'b0, 8'h04, 32'h0,        32'h00000003, 1'b0};
        tbl[10] = '{1'b0, 8'h08, 32'h0,        32'h00000003, 1'b0};
        tbl[11] = '{1'b1, 8'h20, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 8'h20, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b0, 8'h00, 32'h0,        32'h00000021, 1'b0};
        tbl[14] = '{1'b0, 8'h04, 32'h0,        32'h00000003, 1'b0};
        tbl[15] = '{1'b1, 8'h10, 32'h0000FFFF, 32'h0,        1'b0};
        tbl[16] = '{1'b0, 8'h10, 32'h0,        32'h0,        1'b0};

        bus.psel_i    = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.penable_i = 1'b0;
        bus.paddr_i   = 8'h00;
        bus.pwdata_i  = 32'h0;
        bus.int_ack_i = 1'b0;
        src           = 8'h00;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_req",     32'(bus.int_req_o),   32'd0);
        chk("rst_level",   32'(bus.int_level_o), 32'd0);
        chk("rst_vec",     32'(bus.int_vec_o),   32'd0);
        chk("rst_pready",  32'(bus.pready_o),    32'd1);
        chk("rst_pslverr", 32'(bus.pslverr_o),   32'd0);
        chk("rst_prdata",  bus.prdata_o,         32'd0);
        chk("rst_state",   32'(dbg_state),       32'(ST_IDLE));

        // Register map, unused bits, unmapped offset, read-only ISTAT
        run_tbl(0, 16);

        // Edge mode, priorities 2 (src1) and 1 (src0), exact latency
        @(negedge clk);
        src = 8'h03;
        @(negedge clk);
        src = 8'h00;
        @(negedge clk);
        chk("edge_lat_n2_req", 32'(bus.int_req_o), 32'd0);
        @(negedge clk);
        chk("edge_lat_n3_req", 32'(bus.int_req_o), 32'd1);
        chk("edge_first_lvl",  32'(bus.int_level_o), 32'd2);
        chk("edge_first_vec",  32'(bus.int_vec_o),   32'h41);
        ack_pulse();
        chk("ack_a_req",   32'(bus.int_req_o), 32'd0);
        chk("ack_a_state", 32'(dbg_state),     32'(ST_HOLD));
        @(negedge clk);
        chk("ack_a1_req",   32'(bus.int_req_o), 32'd0);
        chk("ack_a1_state", 32'(dbg_state),     32'(ST_IDLE));
        @(negedge clk);
        chk("ack_a2_req", 32'(bus.int_req_o),   32'd1);
        chk("ack_a2_lvl", 32'(bus.int_level_o), 32'd1);
        chk("ack_a2_vec", 32'(bus.int_vec_o),   32'h40);
        ack_pulse();
        repeat (4) @(negedge clk);
        chk("edge_done_req", 32'(bus.int_req_o), 32'd0);
        rd_chk("edge_done_ipend", 8'h0C, 32'h0);

        // Tie: equal priority 5, lowest index first
        wr(8'h00, 32'h00000055);
        @(negedge clk);
        src = 8'h03;
        @(negedge clk);
        src = 8'h00;
        wait_req("tie_first_req", 10);
        chk("tie_first_vec", 32'(bus.int_vec_o),   32'h40);
        chk("tie_first_lvl", 32'(bus.int_level_o), 32'd5);
        ack_pulse();
        wait_req("tie_second_req", 6);
        chk("tie_second_vec", 32'(bus.int_vec_o), 32'h41);
        ack_pulse();
        repeat (4) @(negedge clk);
        chk("tie_done_req", 32'(bus.int_req_o), 32'd0);

        // Level mode on source 2, priority 7
        wr(8'h08, 32'h0);
        wr(8'h00, 32'h00000700);
        wr(8'h04, 32'h00000004);
        @(negedge clk);
        src = 8'h04;
        wait_req("lvl_req", 10);
        chk("lvl_level", 32'(bus.int_level_o), 32'd7);
        chk("lvl_vec",   32'(bus.int_vec_o),   32'h42);
        rd_chk("lvl_istat", 8'h10, 32'h00014207);
        ack_pulse();
        chk("lvl_ack_a_req", 32'(bus.int_req_o), 32'd0);
        @(negedge clk);
        chk("lvl_ack_a1_req", 32'(bus.int_req_o), 32'd0);
        @(negedge clk);
        chk("lvl_repr_req", 32'(bus.int_req_o), 32'd1);
        chk("lvl_repr_vec", 32'(bus.int_vec_o), 32'h42);
        src = 8'h00;
        @(negedge clk);
        chk("lvl_drop_e1_req", 32'(bus.int_req_o), 32'd1);
        @(negedge clk);
        chk("lvl_drop_e2_req", 32'(bus.int_req_o), 32'd0);

        // W1C of pending[0] in the same edge as its edge set: set wins
        wr(8'h08, 32'h00000001);
        @(negedge clk);
        src           = 8'h01;
        bus.psel_i    = 1'b1;
        bus.pwrite_i  = 1'b1;
        bus.penable_i = 1'b0;
        bus.paddr_i   = 8'h0C;
        bus.pwdata_i  = 32'h00000001;
        @(negedge clk);
        bus.penable_i = 1'b1;
        @(negedge clk);
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        src           = 8'h00;
        rd_chk("w1c_race_ipend", 8'h0C, 32'h00000001);
        wr(8'h0C, 32'h00000001);
        rd_chk("w1c_clear_ipend", 8'h0C, 32'h00000000);

        // Masking: all enabled, all priorities 0, all level sources active
        wr(8'h08, 32'h0);
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h000000FF);
        @(negedge clk);
        src = 8'hFF;
        repeat (5) @(negedge clk);
        chk("mask_prio0_req", 32'(bus.int_req_o), 32'd0);
        rd_chk("mask_istat", 8'h10, 32'h0);
        rd_chk("mask_ipend", 8'h0C, 32'h000000FF);
        wr(8'h0C, 32'h000000FF);
        rd_chk("mask_w1c_level_ipend", 8'h0C, 32'h000000FF);
        wr(8'h00, 32'h00000030);
        wait_req("unmask_req", 6);
        chk("unmask_vec", 32'(bus.int_vec_o),   32'h41);
        chk("unmask_lvl", 32'(bus.int_level_o), 32'd3);

        // Reset in the middle of a request
        @(negedge clk);
        rst = 1'b1;
        src = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_req",   32'(bus.int_req_o),   32'd0);
        chk("mid_rst_level", 32'(bus.int_level_o), 32'd0);
        chk("mid_rst_vec",   32'(bus.int_vec_o),   32'd0);
        chk("mid_rst_state", 32'(dbg_state),       32'(ST_IDLE));
        run_tbl(0, 4);
        apb_read(8'h00, d, e);
        chk("mid_rst_final_err", 32'(e), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmt_intc.md
# cmt_intc

Interrupt controller placed directly downstream of the two-channel compare-match timer. It collects `cmt0_int_o`/`cmt1_int_o` plus six further peripheral interrupt lines, latches them as pending, and masks them. It arbitrates by programmable 4-bit priority and presents a single level/vector request to the CPU core with an acknowledge handshake. Configuration goes through the same 8-bit-address, 32-bit-data APB slave style used by the timer.

## Interface
- `NSRC`, 8: number of interrupt sources. Source 0 is cmt0 and source 1 is cmt1.
- `VEC_BASE`, 8'h40: vector number of source 0. Source i presents `VEC_BASE+i`.
- `clk` input 1: system clock (50 MHz). One clock domain.
- `rst` input 1: reset, synchronous and active-high.
- `psel_i`, `pwrite_i`, `penable_i` input 1 each: APB control.
- `paddr_i` input 8: APB byte address.
- `pwdata_i` input 32: APB write data.
- `prdata_o` output 32: APB read data.
- `pslverr_o` output 1: access to an unmapped offset.
- `pready_o` output 1: tied 1, giving zero wait states.
- `src_i` input NSRC: raw interrupt lines, synchronous to `clk`. Bit 0 is `cmt0_int_o`, bit 1 is `cmt1_int_o`.
- `int_req_o` output 1: interrupt request to the CPU.
- `int_level_o` output 4: priority of the presented source.
- `int_vec_o` output 8: vector of the presented source.
- `int_ack_i` input 1: one-cycle CPU acknowledge.

## Operation
- Registers (word offsets). All reset to 0:
  - 0x00 IPR: 4-bit priority per source, source i at bits [4i+3:4i]. Priority 0 disables the source.
  - 0x04 IER: enable per source, bits [NSRC-1:0].
  - 0x08 IMR: mode per source. 1 = rising-edge latched, 0 = level.
  - 0x0C IPEND: pending per source. Reads return the pending state. A write of 1 clears edge-mode pending bits (W1C); writes have no effect on level-mode bits.
  - 0x10 ISTAT (read-only): [3:0] presented level, [15:8] presented vector, [16] `int_req_o`, [17] FSM state is HOLD.
- Any other offset: reads return 0, writes are ignored, and `pslverr_o`=`psel_i & penable_i` for that access. Unused register bits read 0.
- Write strobe: `psel_i & penable_i & pwrite_i`. `prdata_o` is combinational from `paddr_i` while `psel_i`=1, otherwise 0.
- Source capture: `src_q <= src_i` and `src_d <= src_q`.
  - Edge pending sets on `src_q & ~src_d`.
  - Level pending equals `src_q`.
- Candidate set: pending & IER & (IPR≠0).
- Arbitration: the highest IPR value wins. Ties go to the lowest source index.
- FSM with two states:
  - IDLE: outputs are registered from the arbiter every cycle. A new higher-priority candidate replaces the presented one immediately. If no candidate exists, `int_req_o`=0.
  - On `int_ack_i`=1 while `int_req_o`=1: clear the edge pending of the presented source, drive `int_req_o` to 0, and go to HOLD.
  - HOLD: lasts exactly one cycle, with `int_req_o`=0. Then return to IDLE.
  - `int_ack_i` in HOLD or with `int_req_o`=0 is ignored.
- Ack does not clear level-mode sources. They must be cleared at the peripheral, otherwise the source is re-presented after HOLD.
- Simultaneous events:
  - An edge set and a W1C clear or ack clear on the same bit in the same cycle: the set wins.
  - An IER/IPR write takes effect in the arbitration of the next cycle.
- Disabling a source (IER=0 or IPR=0) does not drop its edge-pending bit.

## Timing
- Reset state:
  - All registers, `src_q`, `src_d`: 0.
  - FSM: IDLE.
  - `int_req_o`=0, `int_level_o`=0, `int_vec_o`=0.
  - `prdata_o`=0, `pslverr_o`=0, `pready_o`=1.
- Source-to-request latency:
  - `src_i` rises at edge N. `src_q` updates at edge N+1, and pending is set at N+2 (edge mode) or becomes 1 together with `src_q` (level mode).
  - `int_req_o` rises after edge N+3 in edge mode, N+2 in level mode.
- Ack timing: ack sampled at edge A. `int_req_o`=0 during A..A+1. The next arbitration result is presented from edge A+2.
- Register write at edge W: visible on read from W+1, and in the outputs from W+2.
- Reset asserted mid-request: the next edge clears everything to reset values, including pending bits.

## Structure
- Package `cmt_intc_pkg` holds:
  - Register offset constants.
  - The FSM state typedef (IDLE, HOLD).
  - `NSRC` and `VEC_BASE` defaults.
  - The priority width constant (4).
- Sub-module `cmt_intc_arb`: combinational priority/tie-break tree over the candidate vector. Outputs are `valid`, `level[3:0]` and `idx[2:0]`.
- The top level holds the APB decode, registers, capture flops, pending logic and FSM.

## Test plan
- Reset, then read 0x00–0x10. Required: all read 0, `int_req_o`=0, `pslverr_o`=0.
- IPR=0x21, IER=0x03, IMR=0x03; pulse `src_i[1:0]`=2'b11 for one cycle.
  - Required: request with level 2 and vector 0x41.
  - Ack → one cycle low, then level 1 and vector 0x40.
  - Ack → `int_req_o` stays 0 and IPEND=0.
- Tie: IPR=0x55, both edge sources pulsed. Required: vector 0x40 first, 0x41 after ack.
- Level mode: IMR=0, IPR[11:8]=7, IER=0x04, `src_i[2]` held high.
  - Required: level 7, vector 0x42. Ack → re-presented after HOLD.
  - Drop `src_i[2]` → `int_req_o`=0 two edges later.
- W1C race: write IPEND=0x01 in the same cycle pending[0] sets from an edge. Required: IPEND reads 0x01.
- Error and masking:
  - Write to 0x20 → `pslverr_o`=1, registers unchanged.
  - IER=0xFF with IPR=0 and sources active → no request.
